// File: rtl/fetch_unit_fp.sv
// Instruction-fetch stage: owns the byte-addressed PC, registers the fetched
// word into an IF/ID slot with valid/ready, handles redirects and halt words.
module fetch_unit_fp #(
  parameter int unsigned          PC_W      = 8,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0]   HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    id_pc_plus4_q, id_pc_plus4_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               fire, advance;

  assign fire    = id_valid_q & id_ready;
  assign advance = (state_q == RUN) & (~id_valid_q | id_ready);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the branches below can infer a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    fetch_count_d = fetch_count_q;

    // A fire flushed by a redirect still counts: the decoder sampled it.
    if (fire && fetch_count_q != CNT_MAX) fetch_count_d = fetch_count_q + 1'b1;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      id_valid_d = 1'b0;
      state_d    = RUN;
    end else if (advance) begin
      id_instr_d    = imem_instruction;
      id_pc_d       = fetch_pc_q;
      id_pc_plus4_d = fetch_pc_q + PC_STEP;
      id_valid_d    = 1'b1;
      // The halt word is presented but fetch_pc parks on its address.
      if (imem_instruction == HALT_WORD) state_d = HALT;
      else fetch_pc_d = fetch_pc_q + PC_STEP;
    end else if (fire) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_pc        = fetch_pc_q;
  assign id_valid       = id_valid_q;
  assign id_instruction = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign halted         = (state_q == HALT);
  assign fetch_count    = fetch_count_q;

endmodule
